// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the core in reset until done.
module imem_boot_loader #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [31:0]       words_loaded
);

  // FLUSH covers the cycle the final word is on the bus, so the core is still in reset.
  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_FLUSH,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_buf;
  logic [31:0] word_idx;
  logic [31:0] len;

  logic        xfer;
  logic        word_complete;
  logic        last_word;
  logic        restart;
  logic [31:0] word_next;

  assign xfer          = byte_valid & byte_ready;
  assign word_complete = xfer & (byte_cnt == 2'd3);
  assign word_next     = {byte_data, asm_buf};
  assign last_word     = (word_idx + 32'd1) == len;
  assign restart       = reload & ((state == ST_DONE) | (state == ST_ERR));
  assign words_loaded  = word_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LEN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LEN: begin
        if (word_complete) begin
          if (word_next == 32'd0) begin
            state_next = ST_DONE;
          end else if (word_next > IMEM_WORDS) begin
            state_next = ST_ERR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_complete && last_word) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: state_next = ST_DONE;
      ST_DONE:  if (reload) state_next = ST_LEN;
      ST_ERR:   if (reload) state_next = ST_LEN;
      default:  state_next = ST_LEN;
    endcase
  end

  always_comb begin
    byte_ready = (state == ST_LEN) | (state == ST_DATA);
    core_rst   = (state != ST_DONE);
    load_done  = (state == ST_DONE);
    load_err   = (state == ST_ERR);
  end

  // Byte assembly, length capture and the registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      asm_buf    <= 24'd0;
      word_idx   <= 32'd0;
      len        <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_buf[7:0]   <= byte_data;
          2'd1:    asm_buf[15:8]  <= byte_data;
          2'd2:    asm_buf[23:16] <= byte_data;
          default: asm_buf        <= asm_buf;
        endcase
        if (byte_cnt == 2'd3) begin
          if (state == ST_LEN) begin
            len      <= word_next;
            word_idx <= 32'd0;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'({word_idx, 2'b00});
            imem_wdata <= word_next;
            word_idx   <= word_idx + 32'd1;
          end
        end
      end
      if (restart) begin
        byte_cnt <= 2'd0;
        word_idx <= 32'd0;
        len      <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: random images against a byte-stream
// reference model that derives expected writes directly from the image bytes.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;
  logic [31:0] words_loaded;

  int compared = 0;
  int mismatched = 0;
  int accepted = 0;

  logic [7:0]  img[$];
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [63:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_len;
  bit          exp_err;

  imem_boot_loader #(.IMEM_WORDS(256), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Records every write pulse and every byte the next edge will transfer.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
    if (!rst && byte_valid && byte_ready === 1'b1) accepted++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic make_image(input int unsigned n);
    img.delete();
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    img.push_back(8'(n >> 16));
    img.push_back(8'(n >> 24));
    for (int i = 0; i < int'(n) * 4; i++) img.push_back(8'($urandom));
  endtask

  // Reference model: length header then little-endian words at 4-byte strides.
  task automatic build_model();
    exp_addr.delete();
    exp_data.delete();
    exp_len = {img[3], img[2], img[1], img[0]};
    exp_err = (exp_len > 32'd256);
    if (!exp_err) begin
      for (int i = 0; i < int'(exp_len); i++) begin
        exp_addr.push_back(64'(i) * 64'd4);
        exp_data.push_back({img[4*i+7], img[4*i+6], img[4*i+5], img[4*i+4]});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = byte_ready;
      tick();
    end
    byte_valid = 1'b0;
    byte_data = 8'($urandom);
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL send_byte timeout byte=%02h ready=%0b want 1", b, byte_ready);
    end
    repeat (gap) tick();
  endtask

  task automatic send_image(input int min_gap, input int max_gap);
    for (int i = 0; i < img.size(); i++)
      send_byte(img[i], (i == img.size() - 1) ? 0 : int'($urandom_range(max_gap, min_gap)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (imem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we got %0b want 0", imem_we); end
    compared++; if (imem_addr !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_addr got %0h want 0", imem_addr); end
    compared++; if (imem_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_wdata got %0h want 0", imem_wdata); end
    compared++; if (core_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_core_rst got %0b want 1", core_rst); end
    compared++; if (load_done !== 1'b0 || load_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags got done=%0b err=%0b want 0 0", load_done, load_err); end
    compared++; if (words_loaded !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_words got %0d want 0", words_loaded); end
    compared++; if (byte_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready got %0b want 1", byte_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    img = '{8'h04, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
            8'hB3, 8'h81, 8'h20, 8'h00, 8'h63, 8'h00, 8'h00, 8'h00};
    build_model();
    clear_got();
    send_image(0, 0);
    compared++; if (imem_we !== 1'b1 || core_rst !== 1'b1 || load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_last_write got we=%0b core_rst=%0b done=%0b want 1 1 0", imem_we, core_rst, load_done); end
    tick();
    compared++; if (core_rst !== 1'b0 || load_done !== 1'b1 || imem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_release got core_rst=%0b done=%0b we=%0b want 0 1 0", core_rst, load_done, imem_we); end
    compared++; if (words_loaded !== 32'd4 || byte_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_words got %0d ready=%0b want 4 0", words_loaded, byte_ready); end
    compared++; if (got_data.size() != 4) begin mismatched++; $display("[TB] FAIL basic_count got %0d want 4", got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      compared++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        mismatched++;
        $display("[TB] FAIL basic_write[%0d] got %0h:%08h want %0h:%08h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    do_reload();
    clear_got();
    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_image(0, 0);
    compared++; if (load_done !== 1'b1 || core_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_done got done=%0b core_rst=%0b want 1 0", load_done, core_rst); end
    tick();
    tick();
    compared++; if (byte_ready !== 1'b0 || got_data.size() != 0) begin mismatched++; $display("[TB] FAIL zero_idle got ready=%0b writes=%0d want 0 0", byte_ready, got_data.size()); end
  endtask

  task automatic test_oversize();
    int acc0;
    do_reload();
    clear_got();
    img = '{8'h01, 8'h01, 8'h00, 8'h00};
    build_model();
    send_image(0, 0);
    compared++; if (load_err !== exp_err || core_rst !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0) begin mismatched++; $display("[TB] FAIL oversize_err got err=%0b core_rst=%0b ready=%0b done=%0b want %0b 1 0 0", load_err, core_rst, byte_ready, load_done, exp_err); end
    acc0 = accepted;
    byte_valid = 1'b1;
    repeat (5) tick();
    byte_valid = 1'b0;
    compared++; if (got_data.size() != 0 || accepted != acc0) begin mismatched++; $display("[TB] FAIL oversize_quiet got writes=%0d accepted=%0d want 0 0", got_data.size(), accepted - acc0); end
    do_reload();
    compared++; if (load_err !== 1'b0 || core_rst !== 1'b1 || byte_ready !== 1'b1 || words_loaded !== 32'd0) begin mismatched++; $display("[TB] FAIL oversize_reload got err=%0b core_rst=%0b ready=%0b words=%0d want 0 1 1 0", load_err, core_rst, byte_ready, words_loaded); end
    make_image(1);
    build_model();
    send_image(0, 0);
    tick();
    compared++; if (got_data.size() != 1 || load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL oversize_next got writes=%0d done=%0b want 1 1", got_data.size(), load_done); end
    else if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin mismatched++; $display("[TB] FAIL oversize_next_word got %0h:%08h want %0h:%08h", got_addr[0], got_data[0], exp_addr[0], exp_data[0]); end
  endtask

  task automatic test_gapped();
    do_reload();
    clear_got();
    make_image(2);
    build_model();
    send_image(2, 2);
    tick();
    compared++; if (got_data.size() != 2 || load_done !== 1'b1 || words_loaded !== 32'd2) begin mismatched++; $display("[TB] FAIL gapped_count got writes=%0d done=%0b words=%0d want 2 1 2", got_data.size(), load_done, words_loaded); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      compared++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        mismatched++;
        $display("[TB] FAIL gapped_write[%0d] got %0h:%08h want %0h:%08h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reload();
    make_image(3);
    img = img[0:9];
    send_image(0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++; if (imem_we !== 1'b0 || imem_addr !== 64'd0 || imem_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL rstmid_bus got we=%0b addr=%0h data=%08h want 0 0 0", imem_we, imem_addr, imem_wdata); end
    compared++; if (core_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || words_loaded !== 32'd0 || byte_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_status got core_rst=%0b done=%0b err=%0b words=%0d ready=%0b want 1 0 0 0 1", core_rst, load_done, load_err, words_loaded, byte_ready); end
    clear_got();
    make_image(1);
    build_model();
    send_image(0, 1);
    tick();
    compared++; if (got_data.size() != 1 || load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_next got writes=%0d done=%0b want 1 1", got_data.size(), load_done); end
    else if (got_addr[0] !== 64'd0 || got_data[0] !== exp_data[0]) begin mismatched++; $display("[TB] FAIL rstmid_word got %0h:%08h want 0:%08h", got_addr[0], got_data[0], exp_data[0]); end
  endtask

  task automatic test_done_hold_and_reload_in_data();
    int acc0;
    acc0 = accepted;
    clear_got();
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b0;
    compared++; if (accepted != acc0 || got_data.size() != 0 || load_done !== 1'b1 || byte_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL done_hold got accepted=%0d writes=%0d done=%0b ready=%0b want 0 0 1 0", accepted - acc0, got_data.size(), load_done, byte_ready); end
    do_reload();
    make_image(3);
    build_model();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    do_reload();
    compared++; if (byte_ready !== 1'b1 || words_loaded !== 32'd1 || core_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL data_reload got ready=%0b words=%0d core_rst=%0b want 1 1 1", byte_ready, words_loaded, core_rst); end
    for (int i = 8; i < img.size(); i++) send_byte(img[i], 0);
    tick();
    compared++; if (got_data.size() != 3 || load_done !== 1'b1) begin mismatched++; $display("[TB] FAIL data_reload_count got writes=%0d done=%0b want 3 1", got_data.size(), load_done); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      compared++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        mismatched++;
        $display("[TB] FAIL data_reload_write[%0d] got %0h:%08h want %0h:%08h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      do_reload();
      clear_got();
      make_image($urandom_range(10, 1));
      build_model();
      send_image(0, int'($urandom_range(2, 0)));
      compared++; if (imem_we !== 1'b1 || core_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL rnd%0d_last got we=%0b core_rst=%0b want 1 1", r, imem_we, core_rst); end
      tick();
      compared++; if (load_done !== 1'b1 || core_rst !== 1'b0 || words_loaded !== exp_len || got_data.size() != exp_data.size()) begin mismatched++; $display("[TB] FAIL rnd%0d_done got done=%0b core_rst=%0b words=%0d writes=%0d want 1 0 %0d %0d", r, load_done, core_rst, words_loaded, got_data.size(), exp_len, exp_data.size()); end
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
        compared++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          mismatched++;
          $display("[TB] FAIL rnd%0d_write[%0d] got %0h:%08h want %0h:%08h", r, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_full_capacity();
    do_reload();
    clear_got();
    make_image(256);
    build_model();
    send_image(0, 0);
    tick();
    compared++; if (load_err !== 1'b0 || load_done !== 1'b1 || words_loaded !== 32'd256 || got_data.size() != 256) begin mismatched++; $display("[TB] FAIL full_done got err=%0b done=%0b words=%0d writes=%0d want 0 1 256 256", load_err, load_done, words_loaded, got_data.size()); end
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      compared++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        mismatched++;
        $display("[TB] FAIL full_write[%0d] got %0h:%08h want %0h:%08h", i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_oversize();
    test_gapped();
    test_rst_mid();
    test_done_hold_and_reload_in_data();
    test_random();
    test_full_capacity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
